uart_rx_frame: RTL and testbench



---
 rtl/uart_rx_frame.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// UART receive frame engine: oversampled start detect, 2-of-3 bit vote, parity/stop check.
// Optional macro UART_RX_SYNC_EN inserts a 2-flop synchronizer on RX_IN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a falling edge on an armed (previously high) line
// S_START  | start bit; aborts back to idle if the vote says high
// S_DATA   | shifting in DATA_WIDTH data bits, LSB first
// S_PARITY | capturing the parity bit (only when latched Parity_En)
// S_STOP   | stop bit; frame verdict issued at its vote sample
module uart_rx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  Parity_En,
  input  logic                  Parity_Type,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err,
  output logic                  Busy
);

  localparam int EW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [EW-1:0] EC_ONE  = EW'(1);
  localparam logic [EW-1:0] EC_S0   = EW'(OVERSAMPLE / 2 - 1);
  localparam logic [EW-1:0] EC_S1   = EW'(OVERSAMPLE / 2);
  localparam logic [EW-1:0] EC_VOTE = EW'(OVERSAMPLE / 2 + 1);
  localparam logic [EW-1:0] EC_LAST = EW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BC_ONE  = BW'(1);
  localparam logic [BW-1:0] BC_LAST = BW'(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state;
  logic [EW-1:0]           edge_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [DATA_WIDTH-1:0]   shreg;
  logic                    samp0;
  logic                    samp1;
  logic                    armed;
  logic                    par_en_q;
  logic                    par_type_q;
  logic                    par_bit_q;
  logic                    rx;
  logic                    vote;
  logic                    par_bad;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge CLK) begin
    if (RST) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], RX_IN};
  end

  assign rx = sync_q[1];
`else
  assign rx = RX_IN;
`endif

  // third sample is the live line value, so the vote is ready on the last sample edge
  assign vote    = (samp0 & samp1) | (samp0 & rx) | (samp1 & rx);
  assign par_bad = par_en_q & (((^shreg) ^ par_type_q) != par_bit_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      samp0      <= 1'b0;
      samp1      <= 1'b0;
      armed      <= 1'b0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      par_bit_q  <= 1'b0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;

      if (state != S_IDLE) begin
        edge_cnt <= (edge_cnt == EC_LAST) ? '0 : edge_cnt + EC_ONE;
        if (edge_cnt == EC_S0) samp0 <= rx;
        if (edge_cnt == EC_S1) samp1 <= rx;
      end

      case (state)
        S_IDLE: begin
          if (rx) armed <= 1'b1;
          if (armed && !rx) begin
            // the detecting cycle already counts as edge 0 of the start bit
            state      <= S_START;
            edge_cnt   <= EC_ONE;
            bit_cnt    <= '0;
            par_en_q   <= Parity_En;
            par_type_q <= Parity_Type;
            Busy       <= 1'b1;
          end
        end

        S_START: begin
          if (edge_cnt == EC_LAST) state <= S_DATA;
          if (edge_cnt == EC_VOTE && vote) begin
            state    <= S_IDLE;
            edge_cnt <= '0;
            Busy     <= 1'b0;
          end
        end

        S_DATA: begin
          // counted at the first sample so the count is settled by the bit's last edge
          if (edge_cnt == EC_S0) bit_cnt <= bit_cnt + BC_ONE;
          if (edge_cnt == EC_VOTE) shreg <= {vote, shreg[DATA_WIDTH-1:1]};
          if (edge_cnt == EC_LAST && bit_cnt == BC_LAST)
            state <= par_en_q ? S_PARITY : S_STOP;
        end

        S_PARITY: begin
          if (edge_cnt == EC_VOTE) par_bit_q <= vote;
          if (edge_cnt == EC_LAST) state <= S_STOP;
        end

        S_STOP: begin
          if (edge_cnt == EC_VOTE) begin
            state    <= S_IDLE;
            edge_cnt <= '0;
            Busy     <= 1'b0;
            if (!vote) begin
              Stp_Err <= 1'b1;
              armed   <= 1'b0;
            end
            if (par_bad) Par_Err <= 1'b1;
            if (vote && !par_bad) begin
              P_DATA     <= shreg;
              Data_Valid <= 1'b1;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: frame table plus hand-built corner sequences,
// pulses checked against a scoreboard of expected verdict cycles.
module tb_uart_rx_frame;

`ifdef UART_RX_SYNC_EN
  localparam int LAT_ADD = 2;
`else
  localparam int LAT_ADD = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic       Parity_En = 1'b0;
  logic       Parity_Type = 1'b0;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Par_Err;
  logic       Stp_Err;
  logic       Busy;

  uart_rx_frame #(.DATA_WIDTH(8), .OVERSAMPLE(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .RX_IN(RX_IN),
    .Parity_En(Parity_En),
    .Parity_Type(Parity_Type),
    .P_DATA(P_DATA),
    .Data_Valid(Data_Valid),
    .Par_Err(Par_Err),
    .Stp_Err(Stp_Err),
    .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] flags;   // {Data_Valid, Par_Err, Stp_Err}
    logic [7:0] pdata;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    bit         pe;
    bit         pt;
    bit         bad_par;
    bit         stop_val;
    bit         flip;
    logic [2:0] flags;
  } vec_t;

  exp_t       exp_q[$];
  vec_t       vecs[7];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] last_good = 8'h00;
  bit         mon_on = 1'b0;
  int         bw_from = 1;
  int         bw_to = 0;
  int         bw_lo = 1;
  int         bw_hi = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  // Drives one frame starting this cycle and queues its expected verdict.
  task automatic send_frame(input logic [7:0] d, input bit pe, input bit pt,
                            input bit bad_par, input bit stop_val, input bit flip,
                            input logic [2:0] flags, input int stop_len,
                            input logic idle_val);
    int   c;
    int   s;
    logic pbit;
    logic v;
    exp_t e;
    c    = cyc;
    s    = 9 + (pe ? 1 : 0);
    pbit = (^d) ^ pt ^ bad_par;
    if (flags[2]) last_good = d;
    e.cyc   = c + s * 8 + 6 + LAT_ADD;
    e.flags = flags;
    e.pdata = last_good;
    exp_q.push_back(e);
    Parity_En   = pe;
    Parity_Type = pt;
    for (int k = 0; k <= s; k++) begin
      for (int j = 0; j < ((k == s) ? stop_len : 8); j++) begin
        if (k == 0)                v = 1'b0;
        else if (k <= 8)           v = d[k-1];
        else if (pe && k == 9)     v = pbit;
        else                       v = stop_val;
        if (flip && k >= 1 && k <= 8 && j == 3) v = ~v;
        RX_IN = v;
        // mid-frame changes to the parity controls must be ignored
        if (k == 0 && j == 1 + LAT_ADD) begin
          Parity_En   = ~pe;
          Parity_Type = ~pt;
        end
        next_cycle();
      end
    end
    RX_IN       = idle_val;
    Parity_En   = 1'b0;
    Parity_Type = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (mon_on) begin
      if (Data_Valid || Par_Err || Stp_Err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", int'({Data_Valid, Par_Err, Stp_Err}), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("pulse_flags", int'({Data_Valid, Par_Err, Stp_Err}), int'(e.flags));
          chk("p_data", int'(P_DATA), int'(e.pdata));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("missing_pulse", 0, int'(e.flags));
      end
      if (cyc >= bw_from && cyc <= bw_to)
        chk("busy", int'(Busy), (cyc >= bw_lo && cyc <= bw_hi) ? 1 : 0);
    end
  end

  initial begin
    int c;
    int g;

    vecs[0] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010};
    vecs[2] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b100};
    vecs[3] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010};
    vecs[4] = '{8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b011};
    vecs[5] = '{8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b100};
    vecs[6] = '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b100};

    idle(3);
    RST = 1'b0;
    chk("reset_outputs", int'({P_DATA, Data_Valid, Par_Err, Stp_Err, Busy}), 0);
    mon_on = 1'b1;
    idle(10);

    // first frame on a line held high since reset
    c = cyc;
    bw_from = c; bw_to = c + 79 + LAT_ADD;
    bw_lo = c + 1 + LAT_ADD; bw_hi = c + 77 + LAT_ADD;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 8, 1'b1);
    idle(12);

    foreach (vecs[i]) begin
      send_frame(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].bad_par,
                 vecs[i].stop_val, vecs[i].flip, vecs[i].flags, 8, 1'b1);
      idle(12);
    end

    // stop error followed by a long break: no new frames until the line recovers
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 8, 1'b0);
    bw_from = cyc; bw_to = cyc + 200; bw_lo = 1; bw_hi = 0;
    idle(200);
    RX_IN = 1'b1;
    idle(10);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 8, 1'b1);
    idle(12);

    // two-cycle start glitch, then a frame right after the abort
    g = cyc;
    bw_from = g; bw_to = g + 6 + LAT_ADD;
    bw_lo = g + 1 + LAT_ADD; bw_hi = g + 5 + LAT_ADD;
    RX_IN = 1'b0;
    idle(2);
    RX_IN = 1'b1;
    idle(4 + LAT_ADD);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 8, 1'b1);
    idle(12);

    // back-to-back: next start seen in the verdict cycle of the previous frame
    for (int f = 0; f < 2; f++) begin
      send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, f[0], 3'b100, 6, 1'b1);
      send_frame(8'h80, 1'b0, 1'b0, 1'b0, 1'b1, f[0], 3'b100, 8, 1'b1);
      idle(12);
    end

    // reset in the middle of a frame
    c = cyc;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      d = 8'hA5;
      RX_IN = (i < 8) ? 1'b0 : d[i/8 - 1];
      next_cycle();
    end
    RST = 1'b1;
    RX_IN = 1'b1;
    next_cycle();
    RST = 1'b0;
    last_good = 8'h00;
    chk("midframe_reset", int'({P_DATA, Data_Valid, Par_Err, Stp_Err, Busy}), 0);
    idle(100);
    send_frame(8'h69, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 8, 1'b1);
    idle(20);

    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("leftover_expected", 0, int'(e.flags));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
